// File: rtl/mem_port_arbiter_if.sv
// CPU-side fetch/load-store handshakes plus the single-port Memory bus.
// The arbiter takes the slave view, the CPU/Memory environment the master view.
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ack;

    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port Memory between instruction fetch (I) and load/store (D):
// each access runs IDLE -> ACCESS -> RESP, with D priority bounded by an I starvation counter.
module mem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus,
    output logic               busy
);
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_LIM = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_i_q, owner_i_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          busy_q, busy_d;
    logic          grant_i, grant_d;

    // D wins ties unless I has already waited MAX_WAIT consecutive D grants
    always_comb begin
        grant_i = (state_q == ST_IDLE) && bus.i_req && (!bus.d_req || (wait_cnt_q == WAIT_LIM));
        grant_d = (state_q == ST_IDLE) && bus.d_req && !grant_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (grant_i || grant_d) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        owner_i_d   = owner_i_q;
        wait_cnt_d  = wait_cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (grant_i) begin
                    owner_i_d   = 1'b1;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = '0;
                    mem_read_d  = 1'b1;
                    wait_cnt_d  = '0;
                end else if (grant_d) begin
                    owner_i_d   = 1'b0;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_read_d  = !bus.d_we;
                    mem_write_d = bus.d_we;
                    if (bus.i_req && (wait_cnt_q != WAIT_LIM)) wait_cnt_d = wait_cnt_q + CW'(1);
                end
                if (!bus.i_req) wait_cnt_d = '0;
            end
            ST_ACCESS: begin
                i_ack_d = owner_i_q;
                d_ack_d = !owner_i_q;
                // mem_read_q doubles as the latched "this is a read" flag
                if (mem_read_q) begin
                    if (owner_i_q) i_rdata_d = bus.mem_rdata;
                    else           d_rdata_d = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_i_q   <= 1'b0;
            wait_cnt_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            owner_i_q   <= owner_i_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word-addressed Memory model
// (combinational read, write committed on the falling clock edge).
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    logic busy;
    int   checks;
    int   errors;

    logic [31:0] mem [16];

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_WAIT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus.mem_rdata = mem[bus.mem_addr[5:2]];

    // Memory model: preload, then commit writes on each falling edge
    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 32'h0;
        mem[0] = 32'h8C41000F;
        mem[1] = 32'h11111111;
        mem[2] = 32'h22222222;
        mem[5] = 32'hA5A5A5A5;
        forever begin
            @(negedge clk);
            if (bus.mem_write) mem[bus.mem_addr[5:2]] = bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   32'(busy), 32'h0);
        check({tag, "_iack"},   32'(bus.i_ack), 32'h0);
        check({tag, "_dack"},   32'(bus.d_ack), 32'h0);
        check({tag, "_mrd"},    32'(bus.mem_read), 32'h0);
        check({tag, "_mwr"},    32'(bus.mem_write), 32'h0);
        check({tag, "_maddr"},  bus.mem_addr, 32'h0);
        check({tag, "_mwdata"}, bus.mem_wdata, 32'h0);
        check({tag, "_irdata"}, bus.i_rdata, 32'h0);
        check({tag, "_drdata"}, bus.d_rdata, 32'h0);
    endtask

    logic exp_i [8];
    int   d_ack_seen;

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        #1;
        check_all_zero("reset");
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // I read of word 0
        bus.i_req = 1'b1; bus.i_addr = 32'd0;
        tick();
        check("t2_acc_mrd",  32'(bus.mem_read), 32'h1);
        check("t2_acc_mwr",  32'(bus.mem_write), 32'h0);
        check("t2_acc_busy", 32'(busy), 32'h1);
        check("t2_acc_iack", 32'(bus.i_ack), 32'h0);
        tick();
        check("t2_rsp_iack",  32'(bus.i_ack), 32'h1);
        check("t2_rsp_irdat", bus.i_rdata, 32'h8C41000F);
        check("t2_rsp_busy",  32'(busy), 32'h1);
        check("t2_rsp_mrd",   32'(bus.mem_read), 32'h0);
        bus.i_req = 1'b0;
        tick();
        check("t2_idle_busy", 32'(busy), 32'h0);
        check("t2_idle_iack", 32'(bus.i_ack), 32'h0);

        // D write then read-back at address 16
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd16; bus.d_wdata = 32'hDEADBEEF;
        tick();
        check("t3_w_mwr",   32'(bus.mem_write), 32'h1);
        check("t3_w_mrd",   32'(bus.mem_read), 32'h0);
        check("t3_w_maddr", bus.mem_addr, 32'd16);
        check("t3_w_mwdat", bus.mem_wdata, 32'hDEADBEEF);
        tick();
        check("t3_w_dack",  32'(bus.d_ack), 32'h1);
        check("t3_w_mwr0",  32'(bus.mem_write), 32'h0);
        check("t3_w_mem",   mem[4], 32'hDEADBEEF);
        bus.d_req = 1'b0;
        tick();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd16;
        tick();
        check("t3_r_mrd",   32'(bus.mem_read), 32'h1);
        tick();
        check("t3_r_dack",  32'(bus.d_ack), 32'h1);
        check("t3_r_drdat", bus.d_rdata, 32'hDEADBEEF);
        bus.d_req = 1'b0;
        tick();

        // Contention: both held, MAX_WAIT=3 gives D,D,D,I repeating
        exp_i = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.i_req = 1'b1; bus.i_addr = 32'd4;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd8;
        for (int g = 0; g < 8; g++) begin
            tick();
            tick();
            check($sformatf("t4_g%0d_iack", g), 32'(bus.i_ack), 32'(exp_i[g]));
            check($sformatf("t4_g%0d_dack", g), 32'(bus.d_ack), 32'(!exp_i[g]));
            if (exp_i[g]) check($sformatf("t4_g%0d_irdat", g), bus.i_rdata, 32'h11111111);
            else          check($sformatf("t4_g%0d_drdat", g), bus.d_rdata, 32'h22222222);
            if (g == 7) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
            tick();
        end

        // Late I request during a D read's ACCESS is held off until the next IDLE
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd16;
        tick();
        bus.i_req = 1'b1; bus.i_addr = 32'd0;
        tick();
        check("t6_dack",     32'(bus.d_ack), 32'h1);
        check("t6_iack0",    32'(bus.i_ack), 32'h0);
        check("t6_drdat",    bus.d_rdata, 32'hDEADBEEF);
        bus.d_req = 1'b0;
        tick();
        check("t6_idle",     32'(busy), 32'h0);
        tick();
        check("t6_i_mrd",    32'(bus.mem_read), 32'h1);
        check("t6_i_maddr",  bus.mem_addr, 32'd0);
        tick();
        check("t6_iack",     32'(bus.i_ack), 32'h1);
        check("t6_irdat",    bus.i_rdata, 32'h8C41000F);
        check("t6_drdat_kept", bus.d_rdata, 32'hDEADBEEF);
        bus.i_req = 1'b0;
        tick();

        // Reset asserted inside a write ACCESS, before the falling edge
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'd20; bus.d_wdata = 32'h12345678;
        tick();
        check("t5_mwr_pre", 32'(bus.mem_write), 32'h1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_async");
        bus.d_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        d_ack_seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.d_ack) d_ack_seen++;
        end
        check("t5_no_dack", 32'(d_ack_seen), 32'h0);
        check("t5_mem20",   mem[5], 32'hA5A5A5A5);
        check("t5_busy",    32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
